// File: rtl/debounce_chave_if.sv
// debounce_chave_if: switch-side bundle of the debouncer.
// Macro DEBOUNCE_GLITCH_EN (in the design) enables the bounce counter.
interface debounce_chave_if #(
    parameter int GLITCH_W = 8
);
    logic                chave;
    logic                chave_limpa;
    logic                ocupado;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output chave,
        input  chave_limpa,
        input  ocupado,
        input  glitch_cnt
    );

    modport slave (
        input  chave,
        output chave_limpa,
        output ocupado,
        output glitch_cnt
    );
endinterface

// File: rtl/debounce_chave.sv
// debounce_chave: two-flop synchronizer plus 4-state qualify FSM.
// Define DEBOUNCE_GLITCH_EN to build the saturating bounce counter.
module debounce_chave #(
    parameter int ESTAVEL  = 16,
    parameter int GLITCH_W = 8
) (
    input logic             clk,
    input logic             rst,
    debounce_chave_if.slave bus
);
    localparam int CW = $clog2(ESTAVEL);
    localparam logic [CW-1:0] ULTIMO = CW'(ESTAVEL - 1);

    typedef enum logic [1:0] {
        BAIXO    = 2'd0,
        SUBINDO  = 2'd1,
        ALTO     = 2'd2,
        DESCENDO = 2'd3
    } estado_t;

    estado_t       state_q;
    estado_t       state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sync1;
    logic          sync2;
    logic          limpa_q;
    logic          limpa_d;
    logic          ocupado_q;
    logic          ocupado_d;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.chave;
            sync2 <= sync1;
        end
    end

    // Next state, qualify counter and registered-output precompute.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BAIXO: begin
                if (sync2) begin
                    state_d = SUBINDO;
                    cnt_d   = CW'(1);
                end
            end
            SUBINDO: begin
                if (!sync2) begin
                    state_d = BAIXO;
                end else if (cnt_q == ULTIMO) begin
                    state_d = ALTO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ALTO: begin
                if (!sync2) begin
                    state_d = DESCENDO;
                    cnt_d   = CW'(1);
                end
            end
            DESCENDO: begin
                if (sync2) begin
                    state_d = ALTO;
                end else if (cnt_q == ULTIMO) begin
                    state_d = BAIXO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = BAIXO;
        endcase
        limpa_d   = (state_d == ALTO) || (state_d == DESCENDO);
        ocupado_d = (state_d == SUBINDO) || (state_d == DESCENDO);
    end

    // State register; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BAIXO;
            cnt_q     <= '0;
            limpa_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            limpa_q   <= limpa_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.chave_limpa = limpa_q;
    assign bus.ocupado     = ocupado_q;

`ifdef DEBOUNCE_GLITCH_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch_q;

    // An abort is a qualifying state seeing the old level again.
    assign abort = ((state_q == SUBINDO) && !sync2) ||
                   ((state_q == DESCENDO) && sync2);

    // Saturating bounce counter; reset aborts are never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    assign bus.glitch_cnt = {GLITCH_W{1'b0}};
`endif
endmodule

// File: tb/tb_debounce_chave.sv
// tb_debounce_chave: directed checks of debounce_chave, ESTAVEL=4.
// Glitch expectations follow DEBOUNCE_GLITCH_EN.
module tb_debounce_chave;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic seen_high;

    debounce_chave_if #(.GLITCH_W(8)) bus ();

    debounce_chave #(
        .ESTAVEL (4),
        .GLITCH_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eg(input int n);
`ifdef DEBOUNCE_GLITCH_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input int l, input int o,
                             input int g);
        check({tag, "_limpa"}, int'(bus.chave_limpa), l);
        check({tag, "_ocupado"}, int'(bus.ocupado), o);
        check({tag, "_glitch"}, int'(bus.glitch_cnt), g);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        seen_high = 1'b0;
        rst       = 1'b1;
        bus.chave = 1'b0;

        // reset with a toggling pin
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 0, 0, 0);
            bus.chave = ~bus.chave;
        end
        rst       = 1'b0;
        bus.chave = 1'b0;
        tick();
        tick();
        tick();
        check_out("idle", 0, 0, 0);

        // clean rise: edges 0..5
        bus.chave = 1'b1;
        tick();
        tick();
        check("rise_e1_ocupado", int'(bus.ocupado), 0);
        tick();
        check_out("rise_e2", 0, 1, 0);
        tick();
        tick();
        check_out("rise_e4", 0, 1, 0);
        tick();
        check_out("rise_e5", 1, 0, 0);

        // clean fall
        bus.chave = 1'b0;
        tick();
        tick();
        check("fall_e1_ocupado", int'(bus.ocupado), 0);
        tick();
        check_out("fall_e2", 1, 1, 0);
        tick();
        tick();
        check_out("fall_e4", 1, 1, 0);
        tick();
        check_out("fall_e5", 0, 0, 0);
        tick();
        tick();

        // bounce: 1,1,0 then held high
        bus.chave = 1'b1;
        tick();
        tick();
        bus.chave = 1'b0;
        tick();
        bus.chave = 1'b1;
        tick();
        check_out("bnc_e3", 0, 1, 0);
        tick();
        check_out("bnc_e4", 0, 0, eg(1));
        tick();
        check("bnc_e5_ocupado", int'(bus.ocupado), 1);
        tick();
        tick();
        check_out("bnc_e7", 0, 1, eg(1));
        tick();
        check_out("bnc_e8", 1, 0, eg(1));
        bus.chave = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_out("bnc_low", 0, 0, eg(1));

        // 3-cycle pulse never reaches the clean level
        bus.chave = 1'b1;
        tick();
        tick();
        tick();
        bus.chave = 1'b0;
        tick();
        tick();
        check_out("short_e4", 0, 1, eg(1));
        tick();
        check_out("short_e5", 0, 0, eg(2));
        tick();
        tick();
        tick();
        check_out("short_end", 0, 0, eg(2));

        // 300 two-cycle pulses, checked around the saturation point
        for (int p = 0; p < 252; p++) begin
            bus.chave = 1'b1;
            tick();
            seen_high |= bus.chave_limpa;
            tick();
            seen_high |= bus.chave_limpa;
            bus.chave = 1'b0;
            tick();
            seen_high |= bus.chave_limpa;
            tick();
            seen_high |= bus.chave_limpa;
        end
        tick();
        tick();
        check_out("sat_254", 0, 0, eg(254));
        for (int p = 0; p < 48; p++) begin
            bus.chave = 1'b1;
            tick();
            seen_high |= bus.chave_limpa;
            tick();
            seen_high |= bus.chave_limpa;
            bus.chave = 1'b0;
            tick();
            seen_high |= bus.chave_limpa;
            tick();
            seen_high |= bus.chave_limpa;
        end
        tick();
        tick();
        check_out("sat_255", 0, 0, eg(255));
        check("sat_limpa_never", int'(seen_high), 0);

        // reset during qualification
        bus.chave = 1'b1;
        tick();
        tick();
        tick();
        check_out("rstq_busy", 0, 1, eg(255));
        rst = 1'b1;
        tick();
        check_out("rstq_rst", 0, 0, 0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_out("rstq_e2", 0, 1, 0);
        tick();
        tick();
        tick();
        check_out("rstq_e5", 1, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
